// File: rtl/lh_hdecim3.sv
// lh_hdecim3 -- horizontal [1 2 1]/4 low-pass filter with decimate-by-2.
//
// Filters each raster row of LINE_W pixels with a binomial kernel. The left
// edge is replicated (x[-1] = x[0]). One output token is emitted for every
// second input pixel. Ports follow the RIPL DATA/COUNT/SEND/ACK/RDY token
// convention.
//
// Build option:
//   LH_HDECIM3_ROUND_EN  defined   -> round half up (adds 2 before the >>2)
//                        undefined -> truncate
//
// Ports:
//   CLK         clock, rising edge
//   RESET       asynchronous active-low reset
//   In1_DATA    input pixel token
//   In1_COUNT   upstream token count (ignored)
//   In1_SEND    input token valid
//   In1_ACK     combinational accept of the current In1 token
//   Out1_DATA   filtered, decimated pixel (registered, held between outputs)
//   Out1_COUNT  constant 1
//   Out1_SEND   one-cycle pulse marking a valid output token
//   Out1_ACK    reserved (unused)
//   Out1_RDY    downstream can take a token; sampled only on odd-pixel accept
//
// State  | meaning
// FIRST  | waiting for x[0] of a row; seeds the replicated left edge
// EVEN   | waiting for x[2k], k >= 1
// ODD    | waiting for x[2k+1]; accepting it produces y[k]

module lh_hdecim3 #(
  parameter int DATA_W = 16,
  parameter int LINE_W = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] In1_DATA,
  input  logic [15:0]       In1_COUNT,
  input  logic              In1_SEND,
  output logic              In1_ACK,
  output logic [DATA_W-1:0] Out1_DATA,
  output logic [15:0]       Out1_COUNT,
  output logic              Out1_SEND,
  input  logic              Out1_ACK,
  input  logic              Out1_RDY
);

  localparam int               COL_W    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);
  localparam int               SUM_W    = DATA_W + 2;

`ifdef LH_HDECIM3_ROUND_EN
  localparam logic [SUM_W-1:0] RND = SUM_W'(2);
`else
  localparam logic [SUM_W-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_EVEN  = 2'd1,
    ST_ODD   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] ctr_q, ctr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_send_q, out_send_d;
  logic              ack;
  logic [SUM_W-1:0]  sum;
  logic              unused_ok;

  // prev holds x[2k-1] (or x[0] at the row start), ctr holds x[2k], and the
  // incoming odd pixel supplies x[2k+1]. Max sum is 4*(2^DATA_W-1)+2, which
  // fits in DATA_W+2 bits.
  assign sum = {2'b00, prev_q} + {1'b0, ctr_q, 1'b0} + {2'b00, In1_DATA} + RND;

  assign unused_ok = ^{In1_COUNT, Out1_ACK, sum[1:0]};

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    prev_d     = prev_q;
    ctr_d      = ctr_q;
    out_data_d = out_data_q;
    out_send_d = 1'b0;
    ack        = 1'b0;

    case (state_q)
      ST_FIRST: begin
        ack = In1_SEND;
        if (ack) begin
          prev_d  = In1_DATA;
          ctr_d   = In1_DATA;
          col_d   = col_q + 1'b1;
          state_d = ST_ODD;
        end
      end
      ST_EVEN: begin
        ack = In1_SEND;
        if (ack) begin
          ctr_d   = In1_DATA;
          col_d   = col_q + 1'b1;
          state_d = ST_ODD;
        end
      end
      ST_ODD: begin
        // Downstream readiness gates only the pixel that produces an output.
        ack = In1_SEND & Out1_RDY;
        if (ack) begin
          out_data_d = sum[SUM_W-1:2];
          out_send_d = 1'b1;
          prev_d     = In1_DATA;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_FIRST;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = ST_EVEN;
          end
        end
      end
      default: begin
        state_d = ST_FIRST;
        col_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_FIRST;
      col_q      <= '0;
      prev_q     <= '0;
      ctr_q      <= '0;
      out_data_q <= '0;
      out_send_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      prev_q     <= prev_d;
      ctr_q      <= ctr_d;
      out_data_q <= out_data_d;
      out_send_q <= out_send_d;
    end
  end

  // No token may be consumed while the actor is held in reset.
  assign In1_ACK    = ack & RESET;
  assign Out1_DATA  = out_data_q;
  assign Out1_SEND  = out_send_q;
  assign Out1_COUNT = 16'h0001;

endmodule

// File: tb/tb_lh_hdecim3.sv
// Scoreboard testbench for lh_hdecim3 (LINE_W = 8, DATA_W = 16).
// Expected outputs for a whole row come from a reference model of the kernel;
// a monitor compares every Out1_SEND against the queue, including latency.

module tb_lh_hdecim3;

  localparam int DW = 16;
  localparam int LW = 8;
`ifdef LH_HDECIM3_ROUND_EN
  localparam int RND = 2;
`else
  localparam int RND = 0;
`endif

  typedef logic [DW-1:0] row_t [LW];

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [DW-1:0] In1_DATA = '0;
  logic [15:0]   In1_COUNT = 16'd0;
  logic          In1_SEND = 1'b0;
  logic          In1_ACK;
  logic [DW-1:0] Out1_DATA;
  logic [15:0]   Out1_COUNT;
  logic          Out1_SEND;
  logic          Out1_ACK = 1'b0;
  logic          Out1_RDY = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_q[$];
  int exp_cyc[$];

  lh_hdecim3 #(.DATA_W(DW), .LINE_W(LW)) dut (
    .CLK(CLK), .RESET(RESET),
    .In1_DATA(In1_DATA), .In1_COUNT(In1_COUNT), .In1_SEND(In1_SEND), .In1_ACK(In1_ACK),
    .Out1_DATA(Out1_DATA), .Out1_COUNT(Out1_COUNT), .Out1_SEND(Out1_SEND),
    .Out1_ACK(Out1_ACK), .Out1_RDY(Out1_RDY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: y[k] = (x[2k-1] + 2 x[2k] + x[2k+1] + RND) / 4, x[-1] = x[0].
  function automatic void push_row_expect(input row_t x);
    int left;
    for (int k = 0; k < LW / 2; k++) begin
      left = (k == 0) ? int'(x[0]) : int'(x[2*k-1]);
      exp_q.push_back((left + 2 * int'(x[2*k]) + int'(x[2*k+1]) + RND) / 4);
    end
  endfunction

  always @(negedge CLK) begin
    int e, c;
    if (RESET && Out1_SEND) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_send: got data %0d with no expected output", Out1_DATA);
      end else begin
        e = exp_q.pop_front();
        c = (exp_cyc.size() != 0) ? exp_cyc.pop_front() : -1;
        check("out_data", int'(Out1_DATA), e);
        check("send_latency_cycle", cyc, c);
        check("out_count", int'(Out1_COUNT), 1);
      end
    end
  end

  task automatic rdy_step(input bit rnd_rdy);
    if (rnd_rdy) Out1_RDY = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_px(input logic [DW-1:0] x, input bit odd, input bit gaps, input bit rnd_rdy);
    int budget;
    int ngap;
    bit got;
    if (gaps) begin
      ngap = $urandom_range(0, 2);
      for (int i = 0; i < ngap; i++) begin
        In1_SEND = 1'b0;
        In1_DATA = DW'($urandom);
        @(negedge CLK);
        check("no_ack_when_idle", int'(In1_ACK), 0);
        @(posedge CLK); #1;
        rdy_step(rnd_rdy);
      end
    end
    In1_DATA = x;
    In1_SEND = 1'b1;
    budget = 0;
    got = 1'b0;
    while (!got && budget < 64) begin
      @(negedge CLK);
      if (In1_ACK) begin
        got = 1'b1;
        if (odd) exp_cyc.push_back(cyc + 1);
      end
      @(posedge CLK); #1;
      rdy_step(rnd_rdy);
      budget++;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout: got no ACK expected ACK for pixel %0d", x);
    end
    In1_SEND = 1'b0;
  endtask

  task automatic drive_row(input row_t x, input bit gaps, input bit rnd_rdy);
    push_row_expect(x);
    for (int i = 0; i < LW; i++) drive_px(x[i], i[0], gaps, rnd_rdy);
  endtask

  row_t r_ramp, r_max, r_seq, r_hund, r_rand;

  initial begin
    for (int i = 0; i < LW; i++) begin
      r_ramp[i] = DW'(10 * (i + 1));
      r_max[i]  = 16'hFFFF;
      r_seq[i]  = DW'(i);
      r_hund[i] = DW'(100);
    end

    // Reset state, with a token offered to prove ACK is blocked.
    In1_SEND = 1'b1;
    In1_DATA = 16'd1234;
    repeat (2) @(negedge CLK);
    check("rst_out_send", int'(Out1_SEND), 0);
    check("rst_out_data", int'(Out1_DATA), 0);
    check("rst_in_ack", int'(In1_ACK), 0);
    check("rst_out_count", int'(Out1_COUNT), 1);
    In1_SEND = 1'b0;
    #2 RESET = 1'b1;
    @(posedge CLK); #1;

    // 1: basic ramp row, continuous input.
    drive_row(r_ramp, 1'b0, 1'b0);
    // 2: full-scale row.
    drive_row(r_max, 1'b0, 1'b0);

    // 3: downstream stall while x3 is presented.
    push_row_expect(r_ramp);
    for (int i = 0; i < 3; i++) drive_px(r_ramp[i], i[0], 1'b0, 1'b0);
    Out1_RDY = 1'b0;
    In1_DATA = r_ramp[3];
    In1_SEND = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_ack_low", int'(In1_ACK), 0);
      check("stall_no_send", int'(Out1_SEND), 0);
      @(posedge CLK); #1;
    end
    Out1_RDY = 1'b1;
    for (int i = 3; i < LW; i++) drive_px(r_ramp[i], i[0], 1'b0, 1'b0);

    // 4: back-to-back rows, no bleed across the boundary.
    drive_row(r_seq, 1'b0, 1'b0);
    drive_row(r_hund, 1'b0, 1'b0);

    // 5: reset after x4; partial row discarded.
    push_row_expect(r_ramp);
    for (int i = 0; i < 5; i++) drive_px(r_ramp[i], i[0], 1'b0, 1'b0);
    In1_DATA = r_ramp[5];
    In1_SEND = 1'b1;
    #1 RESET = 1'b0;
    #1;
    check("midrst_out_data", int'(Out1_DATA), 0);
    check("midrst_out_send", int'(Out1_SEND), 0);
    check("midrst_in_ack", int'(In1_ACK), 0);
    check("midrst_pending_outputs", exp_q.size(), 2);
    exp_q.delete();
    exp_cyc.delete();
    @(negedge CLK);
    @(negedge CLK);
    In1_SEND = 1'b0;
    #2 RESET = 1'b1;
    @(posedge CLK); #1;
    drive_row(r_ramp, 1'b0, 1'b0);

    // 6: gapped input, then random data with random downstream readiness.
    drive_row(r_ramp, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < LW; i++) r_rand[i] = DW'($urandom);
      drive_row(r_rand, 1'b1, 1'b1);
    end
    Out1_RDY = 1'b1;

    repeat (5) @(posedge CLK);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
